ctrl_hazard_pipe: RTL and testbench
===================================

# ctrl_hazard_pipe

Registered main-control and hazard unit for the 5-stage MIPS pipeline, replacing the purely combinational ID-stage decoder. Decodes the ID opcode and carries control through ID/EX, EX/MEM and MEM/WB registers. Detects load-use and branch-operand hazards and inserts bubbles. Issues PC-source and IF flush for taken branches and jumps.

## Interface
- `REG_W`, 5, register-address width.
- `LU_STALL`, 1, bubbles inserted per load-use hazard; legal range 1..3.
- `HAS_BNE`, 1, when 1 decode bne (000101); when 0 treat it as illegal.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `valid_i`  in  1  IF/ID holds a real instruction.
- `op_i`  in  6  opcode in ID.
- `rs_i`, `rt_i`, `rd_i`  in  REG_W  ID register fields.
- `eq_i`  in  1  ID comparator result, rs==rt.
- `id_ex_o`  out  8  registered ID/EX control: {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst}.
- `ex_mem_o`  out  4  registered {RegWrite, MemtoReg, MemRead, MemWrite}.
- `mem_wb_o`  out  2  registered {RegWrite, MemtoReg}.
- `pc_write_o`  out  1  PC enable (combinational).
- `if_id_write_o`  out  1  IF/ID enable (combinational).
- `if_flush_o`  out  1  zero IF/ID on next edge (combinational).
- `pc_src_o`  out  2  00 PC+4, 01 branch target, 10 jump target (combinational).
- `illegal_o`  out  1  sticky; set on a valid unknown opcode, cleared only by reset.

## Operation
- Decode, with no X values:
  - lw 100011 → 11101000.
  - sw 101011 → 00011000.
  - beq 000100 → 00000010.
  - bne 000101 → 00000010.
  - R-type 000000 → 10000101.
  - addi 001000 → 10001000.
  - j 000010 → 00000000.
  - Unknown → 00000000 and set `illegal_o`.
  - `valid_i`=0 → 00000000.
- Destination register:
  - R-type uses `rd_i`.
  - lw and addi use `rt_i`.
  - Otherwise the destination is 0.
  - The destination is registered alongside ID/EX and EX/MEM as `ex_dst` and `mem_dst`.
- Register reads:
  - rs is read by every opcode except j.
  - rt is read only by R-type, sw, beq and bne.
- Load-use hazard: ID/EX MemRead=1 and ex_dst≠0 and ex_dst equals a read register of the ID instruction.
- Branch-operand hazard: the ID instruction is beq/bne and either:
  - ID/EX RegWrite=1 with ex_dst≠0 matching rs or rt (1 bubble), or
  - EX/MEM MemRead=1 with mem_dst≠0 matching rs or rt (1 bubble).
- FSM states:
  - RUN: if a hazard exists, insert a bubble (ID/EX←0), hold PC and IF/ID (`pc_write_o`=`if_id_write_o`=0). For load-use, load cnt←LU_STALL−1 and go to WAIT when cnt would be >0. Branch hazards re-evaluate next cycle and stay in RUN.
  - WAIT: bubble and hold; cnt decrements; at cnt==0 return to RUN. While in WAIT, hazard detection against bubble entries is ignored.
- Control flow (only when not stalling):
  - beq with eq_i=1, or bne with eq_i=0 → `pc_src_o`=01, `if_flush_o`=1.
  - j → `pc_src_o`=10, `if_flush_o`=1.
  - The branch/jump itself still enters ID/EX.
  - During a stall `pc_src_o`=00 and `if_flush_o`=0.
- Pipeline advance: every cycle ID/EX→EX/MEM→MEM/WB; there is no back-end stall.

## Timing
- Reset (synchronous): all stage registers 0, dst registers 0, FSM=RUN, cnt=0, `illegal_o`=0.
- During reset and the first cycle after it: `pc_write_o`=1, `if_id_write_o`=1, `if_flush_o`=0, `pc_src_o`=00.
- Latency:
  - ID decode appears on `id_ex_o` 1 cycle after the edge.
  - `ex_mem_o` after 2 cycles.
  - `mem_wb_o` after 3 cycles.
- Stall length: load-use stalls are exactly LU_STALL cycles; branch-after-load totals LU_STALL+1 cycles.
- Simultaneous events:
  - Hazard and taken branch in the same cycle: the hazard wins and the branch resolves after the stall.
  - Reset mid-stall: reset wins and no bubble remains.
- Reading $zero: register 0 never triggers a hazard.

## Structure
- Shared package `ctrl_pkg` holds:
  - opcode localparams;
  - control-bit index constants;
  - the 8-bit decode constants;
  - the PC-source enum {PC_SEQ, PC_BR, PC_JMP};
  - the FSM state enum {RUN, WAIT}.
- One sub-module, `ctrl_decode`: purely combinational opcode → {ctrl[7:0], reads_rs, reads_rt, dst_sel, is_br, is_bne, is_j, illegal}.

## Test plan
- lw r2 then add r3,r2,r4 with LU_STALL=1 → exactly 1 cycle with `pc_write_o`=0; `id_ex_o`=00000000 in the bubble; then 10000101.
- Same sequence with LU_STALL=3 → 3 stall cycles; `ex_mem_o` shows 1110 two cycles after the lw.
- add r5,... then beq r5,r0 with eq_i=1 → 1 stall; next cycle `pc_src_o`=01 and `if_flush_o`=1.
- j with valid_i=1 → `pc_src_o`=10 and `if_flush_o`=1 in the same cycle, no stall; `id_ex_o`=0 next cycle.
- op 111111 → `illegal_o` set and held across 10 legal instructions; rst_i clears it.
- rst_i asserted during a WAIT cycle → next cycle all outputs at reset values and FSM=RUN.

Source files
------------

// File: rtl/ctrl_hazard_pipe_pkg.sv
// Shared constants and types for the registered main-control / hazard unit.
package ctrl_pkg;

    // Opcodes decoded in ID
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Bit positions inside the 8-bit ID/EX control word
    localparam int unsigned CB_REGWRITE = 7;
    localparam int unsigned CB_MEMTOREG = 6;
    localparam int unsigned CB_MEMREAD  = 5;
    localparam int unsigned CB_MEMWRITE = 4;
    localparam int unsigned CB_ALUSRC   = 3;
    localparam int unsigned CB_ALUOP_HI = 2;
    localparam int unsigned CB_ALUOP_LO = 1;
    localparam int unsigned CB_REGDST   = 0;

    // Bit position of MemRead inside the 4-bit EX/MEM control word
    localparam int unsigned EM_MEMREAD = 1;

    // Decode results {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst}
    localparam logic [7:0] CTRL_LW    = 8'b1110_1000;
    localparam logic [7:0] CTRL_SW    = 8'b0001_1000;
    localparam logic [7:0] CTRL_BR    = 8'b0000_0010;
    localparam logic [7:0] CTRL_RTYPE = 8'b1000_0101;
    localparam logic [7:0] CTRL_ADDI  = 8'b1000_1000;
    localparam logic [7:0] CTRL_NONE  = 8'b0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JMP = 2'b10
    } pc_src_t;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DST_NONE = 2'b00,
        DST_RT   = 2'b01,
        DST_RD   = 2'b10
    } dst_sel_t;

endpackage

// File: rtl/ctrl_hazard_pipe_if.sv
// ID-stage inputs and pipeline control outputs of the hazard unit.
interface ctrl_hazard_pipe_if #(
    parameter int REG_W = 5
);
    logic             valid_i;
    logic [5:0]       op_i;
    logic [REG_W-1:0] rs_i;
    logic [REG_W-1:0] rt_i;
    logic [REG_W-1:0] rd_i;
    logic             eq_i;
    logic [7:0]       id_ex_o;
    logic [3:0]       ex_mem_o;
    logic [1:0]       mem_wb_o;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             if_flush_o;
    logic [1:0]       pc_src_o;
    logic             illegal_o;

    modport master (
        output valid_i, op_i, rs_i, rt_i, rd_i, eq_i,
        input  id_ex_o, ex_mem_o, mem_wb_o, pc_write_o, if_id_write_o,
               if_flush_o, pc_src_o, illegal_o
    );

    modport slave (
        input  valid_i, op_i, rs_i, rt_i, rd_i, eq_i,
        output id_ex_o, ex_mem_o, mem_wb_o, pc_write_o, if_id_write_o,
               if_flush_o, pc_src_o, illegal_o
    );
endinterface

// File: rtl/ctrl_hazard_pipe_decode.sv
// Combinational opcode decoder: control word, register usage and flow class.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int HAS_BNE = 1
) (
    input  logic       valid,
    input  logic [5:0] op,
    output logic [7:0] ctrl,
    output logic       reads_rs,
    output logic       reads_rt,
    output dst_sel_t   dst_sel,
    output logic       is_br,
    output logic       is_bne,
    output logic       is_j,
    output logic       illegal
);

    // Opcode lookup; an empty IF/ID slot decodes to all zeros
    always_comb begin
        ctrl     = CTRL_NONE;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        dst_sel  = DST_NONE;
        is_br    = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        illegal  = 1'b0;
        if (valid) begin
            reads_rs = 1'b1;
            case (op)
                OP_LW: begin
                    ctrl    = CTRL_LW;
                    dst_sel = DST_RT;
                end
                OP_SW: begin
                    ctrl     = CTRL_SW;
                    reads_rt = 1'b1;
                end
                OP_BEQ: begin
                    ctrl     = CTRL_BR;
                    reads_rt = 1'b1;
                    is_br    = 1'b1;
                end
                OP_BNE: begin
                    if (HAS_BNE != 0) begin
                        ctrl     = CTRL_BR;
                        reads_rt = 1'b1;
                        is_br    = 1'b1;
                        is_bne   = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OP_RTYPE: begin
                    ctrl     = CTRL_RTYPE;
                    reads_rt = 1'b1;
                    dst_sel  = DST_RD;
                end
                OP_ADDI: begin
                    ctrl    = CTRL_ADDI;
                    dst_sel = DST_RT;
                end
                OP_J: begin
                    reads_rs = 1'b0;
                    is_j     = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_hazard_pipe.sv
// Registered main control with load-use / branch-operand stall and branch/jump redirect.
module ctrl_hazard_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LU_STALL = 1,
    parameter int HAS_BNE  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ctrl_hazard_pipe_if.slave bus
);

    logic [7:0]       ctrl;
    logic             reads_rs;
    logic             reads_rt;
    dst_sel_t         dst_sel;
    logic             is_br;
    logic             is_bne;
    logic             is_j;
    logic             dec_illegal;
    logic [REG_W-1:0] id_dst;

    logic [7:0]       id_ex;
    logic [3:0]       ex_mem;
    logic [1:0]       mem_wb;
    logic [REG_W-1:0] ex_dst;
    logic [REG_W-1:0] mem_dst;
    logic             illegal;

    state_t           state;
    state_t           state_next;
    logic [1:0]       cnt;
    logic [1:0]       cnt_next;
    logic [1:0]       lu_load;
    logic             stall;
    logic             lu_haz;
    logic             br_haz;
    logic             ex_hit_rs;
    logic             ex_hit_rt;
    logic             mem_hit;
    pc_src_t          pc_src;
    logic             flush;

    ctrl_decode #(.HAS_BNE(HAS_BNE)) u_decode (
        .valid    (bus.valid_i),
        .op       (bus.op_i),
        .ctrl     (ctrl),
        .reads_rs (reads_rs),
        .reads_rt (reads_rt),
        .dst_sel  (dst_sel),
        .is_br    (is_br),
        .is_bne   (is_bne),
        .is_j     (is_j),
        .illegal  (dec_illegal)
    );

    // Destination register of the ID instruction
    always_comb begin
        id_dst = '0;
        case (dst_sel)
            DST_RT:  id_dst = bus.rt_i;
            DST_RD:  id_dst = bus.rd_i;
            default: id_dst = '0;
        endcase
    end

    // Hazard detection; $zero never matches
    always_comb begin
        ex_hit_rs = (ex_dst != '0) && (ex_dst == bus.rs_i);
        ex_hit_rt = (ex_dst != '0) && (ex_dst == bus.rt_i);
        mem_hit   = (mem_dst != '0) && ((mem_dst == bus.rs_i) || (mem_dst == bus.rt_i));
        lu_haz    = id_ex[CB_MEMREAD] && ((reads_rs && ex_hit_rs) || (reads_rt && ex_hit_rt));
        br_haz    = is_br && ((id_ex[CB_REGWRITE] && (ex_hit_rs || ex_hit_rt)) ||
                              (ex_mem[EM_MEMREAD] && mem_hit));
    end

    // Stall FSM next state: RUN inserts bubbles on hazards, WAIT counts out load-use bubbles
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        // The EX/MEM load check that a branch would need is masked by WAIT,
        // so the extra branch bubble is counted into the load-use stall here.
        lu_load    = is_br ? 2'(LU_STALL) : 2'(LU_STALL - 1);
        case (state)
            RUN: begin
                if (lu_haz || br_haz) begin
                    stall = 1'b1;
                end
                if (lu_haz) begin
                    cnt_next = lu_load;
                    if (lu_load != 2'd0) begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                stall    = 1'b1;
                cnt_next = cnt - 2'd1;
                if (cnt == 2'd1) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
        if (rst_i) begin
            stall = 1'b0;
        end
    end

    // Redirect for taken branches and jumps, suppressed while stalling or in reset
    always_comb begin
        pc_src = PC_SEQ;
        flush  = 1'b0;
        if (!stall && !rst_i) begin
            if (is_j) begin
                pc_src = PC_JMP;
                flush  = 1'b1;
            end else if (is_br && (is_bne ? !bus.eq_i : bus.eq_i)) begin
                pc_src = PC_BR;
                flush  = 1'b1;
            end
        end
    end

    // Stall FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Pipeline control registers and sticky illegal flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex   <= '0;
            ex_dst  <= '0;
            ex_mem  <= '0;
            mem_dst <= '0;
            mem_wb  <= '0;
            illegal <= 1'b0;
        end else begin
            id_ex   <= stall ? CTRL_NONE : ctrl;
            ex_dst  <= stall ? '0 : id_dst;
            ex_mem  <= id_ex[7:4];
            mem_dst <= ex_dst;
            mem_wb  <= ex_mem[3:2];
            illegal <= illegal | dec_illegal;
        end
    end

    assign bus.id_ex_o       = id_ex;
    assign bus.ex_mem_o      = ex_mem;
    assign bus.mem_wb_o      = mem_wb;
    assign bus.pc_write_o    = !stall;
    assign bus.if_id_write_o = !stall;
    assign bus.if_flush_o    = flush;
    assign bus.pc_src_o      = pc_src;
    assign bus.illegal_o     = illegal;

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Directed bench: two instances (LU_STALL=1 with bne, LU_STALL=3 without bne) share stimulus.
module tb_ctrl_hazard_pipe;

    logic       clk;
    logic       rst;
    logic       v;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       eq;

    int checks;
    int errors;

    ctrl_hazard_pipe_if #(.REG_W(5)) bus_a ();
    ctrl_hazard_pipe_if #(.REG_W(5)) bus_b ();

    assign bus_a.valid_i = v;
    assign bus_a.op_i    = op;
    assign bus_a.rs_i    = rs;
    assign bus_a.rt_i    = rt;
    assign bus_a.rd_i    = rd;
    assign bus_a.eq_i    = eq;
    assign bus_b.valid_i = v;
    assign bus_b.op_i    = op;
    assign bus_b.rs_i    = rs;
    assign bus_b.rt_i    = rt;
    assign bus_b.rd_i    = rd;
    assign bus_b.eq_i    = eq;

    ctrl_hazard_pipe #(.REG_W(5), .LU_STALL(1), .HAS_BNE(1)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    ctrl_hazard_pipe #(.REG_W(5), .LU_STALL(3), .HAS_BNE(0)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock, then present the ID instruction for that cycle
    task automatic cycle(input logic iv, input logic [5:0] iop, input logic [4:0] irs,
                         input logic [4:0] irt, input logic [4:0] ird, input logic ieq);
        @(posedge clk);
        #2;
        v  = iv;
        op = iop;
        rs = irs;
        rt = irt;
        rd = ird;
        eq = ieq;
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    logic [7:0] prev_exp;
    logic [7:0] cur_exp;
    logic [5:0] cur_op;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        v = 1'b0; op = '0; rs = '0; rt = '0; rd = '0; eq = 1'b0;

        // Reset values, during reset and in the first cycle after it
        idle();
        idle();
        chk("rst_id_ex", bus_a.id_ex_o, 8'h00);
        chk("rst_ex_mem", {4'h0, bus_a.ex_mem_o}, 8'h00);
        chk("rst_mem_wb", {6'h0, bus_a.mem_wb_o}, 8'h00);
        chk("rst_pc_write", {7'h0, bus_a.pc_write_o}, 8'h01);
        chk("rst_if_id_write", {7'h0, bus_a.if_id_write_o}, 8'h01);
        chk("rst_flush", {7'h0, bus_a.if_flush_o}, 8'h00);
        chk("rst_pc_src", {6'h0, bus_a.pc_src_o}, 8'h00);
        chk("rst_illegal", {7'h0, bus_a.illegal_o}, 8'h00);
        rst = 1'b0;
        idle();
        chk("post_rst_pc_write", {7'h0, bus_a.pc_write_o}, 8'h01);
        chk("post_rst_pc_src", {6'h0, bus_a.pc_src_o}, 8'h00);

        // lw $2,0($1) then add $3,$2,$4: a stalls 1 cycle, b stalls 3
        cycle(1'b1, 6'b100011, 5'd1, 5'd2, 5'd0, 1'b0);
        chk("lu_c1_pc_write_a", {7'h0, bus_a.pc_write_o}, 8'h01);
        cycle(1'b1, 6'b000000, 5'd2, 5'd4, 5'd3, 1'b0);
        chk("lu_c2_id_ex_lw", bus_a.id_ex_o, 8'b1110_1000);
        chk("lu_c2_pc_write_a", {7'h0, bus_a.pc_write_o}, 8'h00);
        chk("lu_c2_if_id_write_a", {7'h0, bus_a.if_id_write_o}, 8'h00);
        chk("lu_c2_pc_write_b", {7'h0, bus_b.pc_write_o}, 8'h00);
        cycle(1'b1, 6'b000000, 5'd2, 5'd4, 5'd3, 1'b0);
        chk("lu_c3_bubble_a", bus_a.id_ex_o, 8'h00);
        chk("lu_c3_ex_mem_a", {4'h0, bus_a.ex_mem_o}, 8'h0E);
        chk("lu_c3_pc_write_a", {7'h0, bus_a.pc_write_o}, 8'h01);
        chk("lu_c3_ex_mem_b", {4'h0, bus_b.ex_mem_o}, 8'h0E);
        chk("lu_c3_pc_write_b", {7'h0, bus_b.pc_write_o}, 8'h00);
        cycle(1'b1, 6'b000000, 5'd2, 5'd4, 5'd3, 1'b0);
        chk("lu_c4_id_ex_add_a", bus_a.id_ex_o, 8'b1000_0101);
        chk("lu_c4_mem_wb_a", {6'h0, bus_a.mem_wb_o}, 8'h03);
        chk("lu_c4_pc_write_b", {7'h0, bus_b.pc_write_o}, 8'h00);
        cycle(1'b1, 6'b000000, 5'd2, 5'd4, 5'd3, 1'b0);
        chk("lu_c5_bubble_b", bus_b.id_ex_o, 8'h00);
        chk("lu_c5_pc_write_b", {7'h0, bus_b.pc_write_o}, 8'h01);
        idle();
        chk("lu_c6_id_ex_add_b", bus_b.id_ex_o, 8'b1000_0101);

        // add $5 then beq $5,$0 taken: one bubble, branch resolves afterwards
        do_reset();
        cycle(1'b1, 6'b000000, 5'd6, 5'd7, 5'd5, 1'b0);
        cycle(1'b1, 6'b000100, 5'd5, 5'd0, 5'd0, 1'b1);
        chk("br_c2_pc_write", {7'h0, bus_a.pc_write_o}, 8'h00);
        chk("br_c2_pc_src_held", {6'h0, bus_a.pc_src_o}, 8'h00);
        chk("br_c2_flush_held", {7'h0, bus_a.if_flush_o}, 8'h00);
        cycle(1'b1, 6'b000100, 5'd5, 5'd0, 5'd0, 1'b1);
        chk("br_c3_bubble", bus_a.id_ex_o, 8'h00);
        chk("br_c3_pc_write", {7'h0, bus_a.pc_write_o}, 8'h01);
        chk("br_c3_pc_src", {6'h0, bus_a.pc_src_o}, 8'h01);
        chk("br_c3_flush", {7'h0, bus_a.if_flush_o}, 8'h01);
        idle();
        chk("br_c4_id_ex_beq", bus_a.id_ex_o, 8'b0000_0010);

        // add writing $zero then beq $0,$0: no hazard on register 0
        cycle(1'b1, 6'b000000, 5'd6, 5'd7, 5'd0, 1'b0);
        cycle(1'b1, 6'b000100, 5'd0, 5'd0, 5'd0, 1'b1);
        chk("zero_pc_write", {7'h0, bus_a.pc_write_o}, 8'h01);
        chk("zero_pc_src", {6'h0, bus_a.pc_src_o}, 8'h01);

        // j: redirect in the same cycle, no stall
        cycle(1'b1, 6'b000010, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("j_pc_src", {6'h0, bus_a.pc_src_o}, 8'h02);
        chk("j_flush", {7'h0, bus_a.if_flush_o}, 8'h01);
        chk("j_pc_write", {7'h0, bus_a.pc_write_o}, 8'h01);
        chk("j_id_ex_prev_beq", bus_a.id_ex_o, 8'b0000_0010);
        idle();
        chk("j_id_ex", bus_a.id_ex_o, 8'h00);

        // bne not-equal: taken on a, illegal on b
        cycle(1'b1, 6'b000101, 5'd1, 5'd1, 5'd0, 1'b0);
        chk("bne_pc_src_a", {6'h0, bus_a.pc_src_o}, 8'h01);
        chk("bne_flush_a", {7'h0, bus_a.if_flush_o}, 8'h01);
        chk("bne_pc_src_b", {6'h0, bus_b.pc_src_o}, 8'h00);
        idle();
        chk("bne_id_ex_a", bus_a.id_ex_o, 8'b0000_0010);
        chk("bne_id_ex_b", bus_b.id_ex_o, 8'h00);
        chk("bne_illegal_a", {7'h0, bus_a.illegal_o}, 8'h00);
        chk("bne_illegal_b", {7'h0, bus_b.illegal_o}, 8'h01);

        // Unknown opcode sets sticky illegal; held across 10 legal instructions
        cycle(1'b1, 6'b111111, 5'd0, 5'd0, 5'd0, 1'b0);
        prev_exp = 8'h00;
        for (int unsigned i = 0; i < 10; i++) begin
            cur_op  = (i % 2 == 0) ? 6'b001000 : 6'b101011;
            cur_exp = (i % 2 == 0) ? 8'b1000_1000 : 8'b0001_1000;
            cycle(1'b1, cur_op, 5'd9, 5'd10, 5'd0, 1'b0);
            if (i == 0) begin
                chk("ill_set", {7'h0, bus_a.illegal_o}, 8'h01);
            end else begin
                chk("ill_seq_id_ex", bus_a.id_ex_o, prev_exp);
            end
            prev_exp = cur_exp;
        end
        idle();
        chk("ill_last_id_ex", bus_a.id_ex_o, 8'b0001_1000);
        chk("ill_held", {7'h0, bus_a.illegal_o}, 8'h01);
        do_reset();
        chk("ill_cleared", {7'h0, bus_a.illegal_o}, 8'h00);

        // Reset during WAIT on b: reset wins, no bubble or stall remains
        cycle(1'b1, 6'b100011, 5'd1, 5'd2, 5'd0, 1'b0);
        cycle(1'b1, 6'b000000, 5'd2, 5'd4, 5'd3, 1'b0);
        cycle(1'b1, 6'b000000, 5'd2, 5'd4, 5'd3, 1'b0);
        chk("wr_wait_pc_write_b", {7'h0, bus_b.pc_write_o}, 8'h00);
        rst = 1'b1;
        #1;
        chk("wr_in_rst_pc_write_b", {7'h0, bus_b.pc_write_o}, 8'h01);
        idle();
        rst = 1'b0;
        #1;
        chk("wr_id_ex_b", bus_b.id_ex_o, 8'h00);
        chk("wr_ex_mem_b", {4'h0, bus_b.ex_mem_o}, 8'h00);
        chk("wr_mem_wb_b", {6'h0, bus_b.mem_wb_o}, 8'h00);
        chk("wr_pc_write_b", {7'h0, bus_b.pc_write_o}, 8'h01);
        chk("wr_if_id_write_b", {7'h0, bus_b.if_id_write_o}, 8'h01);
        chk("wr_flush_b", {7'h0, bus_b.if_flush_o}, 8'h00);
        chk("wr_pc_src_b", {6'h0, bus_b.pc_src_o}, 8'h00);
        chk("wr_illegal_b", {7'h0, bus_b.illegal_o}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
